alu_pipe_param: RTL and testbench
=================================

ALU_PIPE_PARAM -- requirements
Module: alu_pipe_param

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be a power of two, >= 4.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from OP2[SHW-1:0].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 OPCODE  input  3  operation select, sampled on acceptance.
REQ-008 OP1  input  WIDTH  first operand, unsigned or two's complement per opcode.
REQ-009 OP2  input  WIDTH  second operand or shift amount.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 carry, zero, ovf  output  1 each  registered flags.

Function
REQ-014 Acceptance SHALL occur on a rising edge with in_valid && in_ready; OPCODE/OP1/OP2 captured then, ignored otherwise.
REQ-015 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL (low WIDTH bits of unsigned product).
REQ-016 FSM states SHALL be IDLE, MUL, RESP.
REQ-017 IDLE: accept non-MUL -> RESP; accept MUL -> MUL; else stay.
REQ-018 MUL: iterative shift-add, one operand bit per cycle, exactly WIDTH cycles, then -> RESP.
REQ-019 RESP: out_valid=1; out_ready=0 -> stay, result/flags held stable; out_ready=1 -> IDLE, or straight to RESP/MUL if a new request is accepted that same cycle.
REQ-020 in_ready SHALL be (state==IDLE) || (state==RESP && out_ready); combinational, low throughout MUL.
REQ-021 Latency SHALL be: non-MUL out_valid the cycle after acceptance; MUL out_valid WIDTH+1 cycles after acceptance.
REQ-022 zero SHALL equal (result==0) for every opcode.
REQ-023 carry SHALL be: ADD carry-out; SUB borrow (OP1<OP2 unsigned); SHL/SHR last bit shifted out, 0 for shift amount 0; AND/OR/XOR 0; MUL 1 iff upper WIDTH product bits nonzero.
REQ-024 ovf SHALL be signed overflow for ADD/SUB, 0 otherwise.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-026 While rstn=0 at a rising edge: state=IDLE, out_valid=0, result=0, carry=zero=ovf=0, MUL counter/accumulator cleared.
REQ-027 Reset asserted in MUL or RESP SHALL abort the operation; no out_valid for it afterwards.
REQ-028 in_ready SHALL be 1 the first cycle after rstn rises.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode enum (3 bits) and FSM state typedef.
REQ-030 Iterative multiplier SHALL be sub-module alu_mul_iter (start, operands, done, 2*WIDTH product), parametrised by WIDTH.
REQ-031 Implementation SHALL be synthesizable, no latches, no asynchronous logic.

Verification (WIDTH=8)
REQ-032 rstn=0 two cycles -> out_valid=0, result=0x00, flags 0; in_ready=1 after release.
REQ-033 ADD 0xFF+0x01 -> next cycle result=0x00, carry=1, zero=1, ovf=0.
REQ-034 SUB 0x80-0x01 -> result=0x7F, carry=0, ovf=1; SHR 0x81 by 1 -> 0x40, carry=1.
REQ-035 MUL 0x10*0x10 -> in_ready=0 for 8 cycles, out_valid 9 cycles after accept, result=0x00, carry=1, zero=1.
REQ-036 out_ready=0 three cycles in RESP -> result held; then out_ready=1 with XOR 0xF0^0x0F accepted same cycle -> next cycle result=0xFF.
REQ-037 rstn=0 at MUL cycle 4 -> IDLE, out_valid stays 0, next ADD 0x02+0x03 returns 0x05.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU slice.
//
// Contents:
//   opcode_e : 3-bit operation select seen on OPCODE
//   state_e  : control FSM states of alu_pipe_param
package alu_pkg;

  // Operation encodings as presented on the OPCODE input.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } opcode_e;

  // IDLE waits for work, MUL runs the iterative multiplier,
  // RESP presents a result until the consumer takes it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
//
// Ports:
//   clk       : clock, rising edge
//   rstn      : synchronous active-low reset, clears counter and accumulator
//   start_i   : load a_i/b_i and begin a new multiplication
//   a_i, b_i  : unsigned operands (multiplicand, multiplier)
//   done_o    : high during the cycle in which the final step is taken
//   product_o : full 2*WIDTH product, valid while done_o is high
//
// After start_i the unit takes exactly WIDTH further cycles; done_o is
// high in the last of them and product_o already includes that final
// step, so the caller can register it on the same edge.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] step;

  // One shift-add step: add the shifted multiplicand when the current
  // low multiplier bit is set.
  always_comb begin
    step = acc_q;
    if (mplier_q[0]) begin
      step = acc_q + mcand_q;
    end
  end

  assign product_o = step;
  assign done_o    = busy_q && (count_q == CW'(WIDTH - 1));

  // Operand/accumulator registers. A start loads fresh operands; while
  // busy the multiplicand moves left and the multiplier right each cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe_param.sv
// Handshaked ALU with registered result and flags.
//
// Ports:
//   clk, rstn          : clock and synchronous active-low reset
//   in_valid/in_ready  : request handshake; OPCODE/OP1/OP2 captured on accept
//   OPCODE             : ADD SUB AND OR XOR SHL SHR MUL
//   OP1, OP2           : operands; OP2[SHW-1:0] is the shift amount
//   out_valid/out_ready: response handshake
//   result             : registered WIDTH-bit result
//   carry, zero, ovf   : registered flags
//
// Single-cycle ops respond the cycle after acceptance. MUL runs the
// iterative multiplier for WIDTH cycles and responds WIDTH+1 cycles after
// acceptance. A new request can be accepted in the same cycle that a
// response is consumed.
module alu_pipe_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               isMulOp;
  opcode_e            opcode;
  logic [SHW-1:0]     shAmt;
  logic [WIDTH:0]     sumExt, diffExt, shlExt, shrExt;
  logic [WIDTH-1:0]   aluRes;
  logic               aluCarry, aluOvf;
  logic               mulDone;
  logic [2*WIDTH-1:0] mulProduct;

  assign opcode   = opcode_e'(OPCODE);
  assign isMulOp  = (opcode == OP_MUL);
  assign shAmt    = OP2[SHW-1:0];
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && out_ready);
  assign accept   = in_valid && in_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rstn      (rstn),
    .start_i   (accept && isMulOp),
    .a_i       (OP1),
    .b_i       (OP2),
    .done_o    (mulDone),
    .product_o (mulProduct)
  );

  // Single-cycle datapath. Extended-width add/sub expose carry and borrow
  // in bit WIDTH; shifts are done one bit wider so the last bit shifted
  // out lands in a fixed position (and is 0 for a zero shift amount).
  always_comb begin
    sumExt   = {1'b0, OP1} + {1'b0, OP2};
    diffExt  = {1'b0, OP1} - {1'b0, OP2};
    shlExt   = {1'b0, OP1} << shAmt;
    shrExt   = {OP1, 1'b0} >> shAmt;
    aluRes   = '0;
    aluCarry = 1'b0;
    aluOvf   = 1'b0;
    case (opcode)
      OP_ADD: begin
        aluRes   = sumExt[WIDTH-1:0];
        aluCarry = sumExt[WIDTH];
        aluOvf   = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sumExt[WIDTH-1] != OP1[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes   = diffExt[WIDTH-1:0];
        aluCarry = diffExt[WIDTH];
        aluOvf   = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (diffExt[WIDTH-1] != OP1[WIDTH-1]);
      end
      OP_AND: aluRes = OP1 & OP2;
      OP_OR:  aluRes = OP1 | OP2;
      OP_XOR: aluRes = OP1 ^ OP2;
      OP_SHL: begin
        aluRes   = shlExt[WIDTH-1:0];
        aluCarry = shlExt[WIDTH];
      end
      OP_SHR: begin
        aluRes   = shrExt[WIDTH:1];
        aluCarry = shrExt[0];
      end
      default: ;
    endcase
  end

  // Next-state and output-register logic. The state case handles
  // completion and consumption; an accepted request then overrides,
  // which covers both IDLE and the back-to-back RESP case.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_MUL: begin
        if (mulDone) begin
          state_d  = S_RESP;
          result_d = mulProduct[WIDTH-1:0];
          carry_d  = |mulProduct[2*WIDTH-1:WIDTH];
          zero_d   = (mulProduct[WIDTH-1:0] == '0);
          ovf_d    = 1'b0;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
    if (accept) begin
      if (isMulOp) begin
        state_d = S_MUL;
      end else begin
        state_d  = S_RESP;
        result_d = aluRes;
        carry_d  = aluCarry;
        zero_d   = (aluRes == '0);
        ovf_d    = aluOvf;
      end
    end
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = (state_q == S_RESP);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// Testbench for alu_pipe_param at WIDTH=8: directed vector table,
// hand-written handshake/reset sequences, and random operations checked
// against an arithmetic reference model.
module tb_alu_pipe_param;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] OPCODE;
  logic [7:0] OP1, OP2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry, zero, ovf;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    int    op;
    int    a;
    int    b;
    int    res;
    int    c;
    int    z;
    int    v;
    string name;
  } vec_t;

  typedef struct {
    int res;
    int c;
    int z;
    int v;
  } exp_t;

  vec_t vecs[16];

  alu_pipe_param #(.WIDTH(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .OPCODE    (OPCODE),
    .OP1       (OP1),
    .OP2       (OP2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Record one comparison and report it when it does not hold.
  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference behaviour from plain integer arithmetic on 8-bit values.
  function automatic exp_t refModel(input int op, input int a, input int b);
    exp_t e;
    int   amt, r, sa, sb;
    amt = b % 8;
    sa  = (a > 127) ? a - 256 : a;
    sb  = (b > 127) ? b - 256 : b;
    e.c = 0;
    e.v = 0;
    r   = 0;
    case (op)
      0: begin r = a + b; e.c = (r > 255) ? 1 : 0; e.v = ((sa + sb > 127) || (sa + sb < -128)) ? 1 : 0; end
      1: begin r = a - b; e.c = (a < b) ? 1 : 0; e.v = ((sa - sb > 127) || (sa - sb < -128)) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a << amt; e.c = (amt == 0) ? 0 : ((a >> (8 - amt)) & 1); end
      6: begin r = a >> amt; e.c = (amt == 0) ? 0 : ((a >> (amt - 1)) & 1); end
      default: begin r = a * b; e.c = (r > 255) ? 1 : 0; end
    endcase
    e.res = r & 255;
    e.z   = (e.res == 0) ? 1 : 0;
    return e;
  endfunction

  // Issue one request, wait for its response, optionally stall the
  // consumer, then check result, flags, latency and in_ready behaviour.
  task automatic applyStimulus(input int op, input int a, input int b, input int stall,
                               input int expRes, input int expC, input int expZ,
                               input int expV, input string name);
    int guard;
    int lat;
    int lowCnt;
    @(negedge clk);
    OPCODE    = 3'(op);
    OP1       = 8'(a);
    OP2       = 8'(b);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    lowCnt = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) lowCnt++;
      @(negedge clk);
      lat++;
    end
    repeat (stall) @(negedge clk);
    checkOutput({name, " out_valid"}, int'(out_valid), 1);
    checkOutput({name, " result"}, int'(result), expRes);
    checkOutput({name, " carry"}, int'(carry), expC);
    checkOutput({name, " zero"}, int'(zero), expZ);
    checkOutput({name, " ovf"}, int'(ovf), expV);
    checkOutput({name, " latency"}, lat, (op == 7) ? 9 : 1);
    checkOutput({name, " in_ready low cycles"}, lowCnt, (op == 7) ? 8 : 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int   sawValid;
    exp_t e;
    int   op, a, b;

    vecs[0]  = '{0, 'hFF, 'h01, 'h00, 1, 1, 0, "ADD FF+01"};
    vecs[1]  = '{0, 'h7F, 'h01, 'h80, 0, 0, 1, "ADD 7F+01"};
    vecs[2]  = '{1, 'h80, 'h01, 'h7F, 0, 0, 1, "SUB 80-01"};
    vecs[3]  = '{1, 'h01, 'h02, 'hFF, 1, 0, 0, "SUB 01-02"};
    vecs[4]  = '{2, 'hF0, 'h3C, 'h30, 0, 0, 0, "AND F0&3C"};
    vecs[5]  = '{3, 'h00, 'h00, 'h00, 0, 1, 0, "OR 00|00"};
    vecs[6]  = '{4, 'hAA, 'h55, 'hFF, 0, 0, 0, "XOR AA^55"};
    vecs[7]  = '{5, 'h81, 'h01, 'h02, 1, 0, 0, "SHL 81<<1"};
    vecs[8]  = '{5, 'h81, 'h08, 'h81, 0, 0, 0, "SHL 81<<0"};
    vecs[9]  = '{6, 'h81, 'h01, 'h40, 1, 0, 0, "SHR 81>>1"};
    vecs[10] = '{6, 'h80, 'h07, 'h01, 0, 0, 0, "SHR 80>>7"};
    vecs[11] = '{7, 'h10, 'h10, 'h00, 1, 1, 0, "MUL 10*10"};
    vecs[12] = '{7, 'h0F, 'h0F, 'hE1, 0, 0, 0, "MUL 0F*0F"};
    vecs[13] = '{7, 'hFF, 'hFF, 'h01, 1, 0, 0, "MUL FF*FF"};
    vecs[14] = '{5, 'h01, 'h07, 'h80, 0, 0, 0, "SHL 01<<7"};
    vecs[15] = '{6, 'h01, 'h01, 'h00, 1, 1, 0, "SHR 01>>1"};

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    OPCODE    = '0;
    OP1       = '0;
    OP2       = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset result", int'(result), 0);
    checkOutput("reset flags", int'({carry, zero, ovf}), 0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("reset in_ready after release", int'(in_ready), 1);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].res,
                    vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].name);
    end

    // Response held through a stall, then consumed while a new request
    // is accepted in the same cycle.
    @(negedge clk);
    OPCODE = 3'd1; OP1 = 8'h80; OP2 = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall out_valid", int'(out_valid), 1);
      checkOutput("stall result held", int'(result), 'h7F);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    OPCODE = 3'd4; OP1 = 8'hF0; OP2 = 8'h0F;
    #1;
    checkOutput("back-to-back in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("back-to-back out_valid", int'(out_valid), 1);
    checkOutput("back-to-back result", int'(result), 'hFF);
    checkOutput("back-to-back flags", int'({carry, zero, ovf}), 0);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("idle after consume", int'(out_valid), 0);

    // Reset in the middle of a multiplication aborts it.
    @(negedge clk);
    OPCODE = 3'd7; OP1 = 8'h10; OP2 = 8'h10; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mul busy in_ready", int'(in_ready), 0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("abort out_valid", int'(out_valid), 0);
    checkOutput("abort result", int'(result), 0);
    checkOutput("abort in_ready", int'(in_ready), 1);
    sawValid = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) sawValid = 1;
    end
    checkOutput("abort no late out_valid", sawValid, 0);
    applyStimulus(0, 'h02, 'h03, 0, 'h05, 0, 0, 0, "ADD 02+03 after abort");

    // Random operations against the reference model, with consumer stalls.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      e  = refModel(op, a, b);
      applyStimulus(op, a, b, int'($urandom_range(0, 2)), e.res, e.c, e.z, e.v,
                    $sformatf("rand op%0d %02h,%02h", op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
